dmem_arbiter: RTL
=================

# dmem_arbiter

Sequencing controller and two-way arbiter for the single-port data memory behind the RISC-V datapath. It shares the memory between the core's load/store port and an external loader/debug port, issues one memory strobe per granted access, and waits out the memory read latency. It returns per-port acknowledge and read data, and stalls the core while its access is pending. The block sits between the datapath's `wr`/`rd`/`addr`/`wr_data`/`rd_data` signals and the data memory instance.

## Interface
- `DATA_W`, 32, data width.
- `ADDR_W`, 9, word address width.
- `RD_LAT`, 2, memory read latency in cycles, legal range 1..4.
- `CNT_W`, 16, width of the contention counter.

- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-low.
- `core_req` in 1: core access request, held until `core_ack`.
- `core_we` in 1: 1 = write, 0 = read.
- `core_addr` in ADDR_W: core address.
- `core_wdata` in DATA_W: core write data.
- `core_rdata` out DATA_W: core read data.
- `core_ack` out 1: one-cycle completion pulse to the core.
- `core_stall` out 1: `core_req & ~core_ack` (combinational).
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata` in: loader request fields, with the same meaning and widths as the core fields.
- `ldr_rdata` out DATA_W: loader read data.
- `ldr_ack` out 1: one-cycle completion pulse to the loader.
- `mem_wr` out 1: memory write strobe.
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out ADDR_W: memory address.
- `mem_wr_data` out DATA_W: memory write data.
- `mem_rd_data` in DATA_W: memory read data.
- `busy` out 1: FSM not in IDLE.
- `grant_id` out 1: 0 = core, 1 = loader; the owner of the current or last access.
- `conflict_cnt` out CNT_W: saturating count of contention cycles.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE.
- IDLE
  - Samples `core_req` and `ldr_req`; requests are sampled only in IDLE.
  - If exactly one request is high, that port wins.
  - If both are high, the port that is not `last_grant` wins (round-robin). `last_grant` resets to loader, so the core wins the first tie.
  - The winner's `we`, `addr` and `wdata` are registered, `grant_id` and `last_grant` are updated, and the FSM goes to ISSUE.
  - With no request, the FSM stays in IDLE.
- ISSUE (exactly one cycle)
  - `mem_wr` or `mem_rd` is high according to the registered `we`.
  - `mem_addr` and `mem_wr_data` are driven from the registers.
  - A write goes to DONE; a read goes to WAIT with the latency counter loaded to RD_LAT-1.
- WAIT
  - The counter decrements each cycle.
  - When the counter reaches 0, `mem_rd_data` is captured into the winner's rdata register and the FSM goes to DONE.
  - With RD_LAT=1 the FSM spends one cycle in WAIT with the counter already 0.
- DONE (exactly one cycle)
  - The winner's ack is high for one cycle.
  - The FSM returns to IDLE.
  - The requester must drop or change `req` in the cycle after ack; a `req` still high in IDLE is treated as a new request.
- `core_rdata` and `ldr_rdata` hold their value until the next read completes for that port. Writes do not alter them.
- `conflict_cnt` increments every cycle in which both `req` inputs are high and neither ack is high, and saturates at all-ones.
- Outside ISSUE, `mem_wr` and `mem_rd` are 0. `mem_addr` and `mem_wr_data` hold their last registered value.
- Request fields that change while a request is pending are ignored, because they were registered in IDLE.

## Timing
- Reset (`reset`=0 at a clock edge) has priority over everything:
  - The FSM goes to IDLE.
  - `mem_wr`, `mem_rd`, `core_ack`, `ldr_ack` and `busy` are 0.
  - `mem_addr`, `mem_wr_data`, `core_rdata`, `ldr_rdata`, `conflict_cnt` and `grant_id` are 0.
  - `last_grant` is set to loader.
- Reset mid-access abandons the in-flight access. No ack is produced, and the late `mem_rd_data` is never captured.
- Core and loader timing are symmetric. Cycle 0 is the cycle in which `req` is seen in IDLE.
  - Strobe in cycle 1.
  - Write ack in cycle 2.
  - Read: `mem_rd_data` is sampled at the end of cycle 1+RD_LAT; ack and valid rdata appear in cycle 2+RD_LAT.
- Minimum request-to-request period is 3 cycles for writes and RD_LAT+3 cycles for reads.
- The two strobes are never high together, and at most one ack is high in any cycle.
- A losing requester waits for exactly one access of the other port when that port's request is continuous. Starvation is impossible.

## Test plan
- **Single write then read, RD_LAT=2.** Core writes 0xDEADBEEF to address 0x1A, then reads 0x1A.
  - Write: `mem_wr` in cycle 1, `core_ack` in cycle 2.
  - Read: `mem_rd` in cycle 1, `core_ack` in cycle 4, `core_rdata`=0xDEADBEEF.
  - `core_stall`=1 from request until ack.
- **Tie after reset.** Both ports request reads in the same cycle.
  - Core is granted first; `ldr_ack` follows 5 cycles after `core_ack`.
  - `grant_id` sequence is 0 then 1.
  - `conflict_cnt` equals the number of both-high, no-ack cycles (core access 4).
- **Sustained contention.** Both ports request continuously for 10 accesses each.
  - Grants strictly alternate, starting with core.
  - No ack is lost, and each port's ack count is 10.
- **RD_LAT sweep 1..4.** Run a memory model with the matching delay.
  - Read ack arrives at cycle RD_LAT+2.
  - Captured data matches the memory model.
- **Reset mid-read.** Assert `reset`=0 in the WAIT cycle of a loader read.
  - All outputs reach their reset values at the next edge.
  - No `ldr_ack` is produced, `ldr_rdata` stays 0, and the FSM is IDLE.
- **Counter saturation.** With CNT_W=4, hold contention for over 15 cycles.
  - `conflict_cnt` stops at 0xF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the core load/store port and
//   the loader/debug port. One access is granted at a time (round-robin on a
//   tie). The block issues one memory strobe per access, waits out the memory
//   read latency, and returns a one-cycle ack plus held read data to the
//   owning port.
//
// Ports
//   clk, reset          : clock, synchronous active-low reset
//   core_req/we/addr/wdata : core request fields (held until core_ack)
//   core_rdata, core_ack   : core read data (held), one-cycle completion pulse
//   core_stall             : core_req & ~core_ack (combinational)
//   ldr_req/we/addr/wdata  : loader request fields
//   ldr_rdata, ldr_ack     : loader read data (held), one-cycle completion pulse
//   mem_wr, mem_rd         : memory strobes, high only in ISSUE
//   mem_addr, mem_wr_data  : memory address / write data (hold last grant)
//   mem_rd_data            : memory read data
//   busy                   : FSM not in IDLE
//   grant_id               : 0 = core, 1 = loader; owner of current/last access
//   conflict_cnt           : saturating count of contention cycles
module dmem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              grant_id,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // RD_LAT is limited to 1..4, so the remaining-latency counter needs 2 bits.
  localparam int unsigned        LAT_W      = 2;
  localparam logic [LAT_W-1:0]   LAT_LOAD   = LAT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic               GRANT_CORE = 1'b0;
  localparam logic               GRANT_LDR  = 1'b1;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("dmem_arbiter: RD_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               we_q, we_d;
  logic               last_q, last_d;
  logic               pick_ldr;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d;
  logic               grant_d;
  logic [DATA_W-1:0]  core_rdata_d, ldr_rdata_d;
  logic               core_ack_d, ldr_ack_d;
  logic               mem_wr_d, mem_rd_d;
  logic               busy_d;
  logic [CNT_W-1:0]   cnt_d;

  assign core_stall = core_req & ~core_ack;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    we_d         = we_q;
    last_d       = last_q;
    pick_ldr     = 1'b0;
    addr_d       = mem_addr;
    wdata_d      = mem_wr_data;
    grant_d      = grant_id;
    core_rdata_d = core_rdata;
    ldr_rdata_d  = ldr_rdata;
    core_ack_d   = 1'b0;
    ldr_ack_d    = 1'b0;
    mem_wr_d     = 1'b0;
    mem_rd_d     = 1'b0;
    cnt_d        = conflict_cnt;

    case (state_q)
      S_IDLE: begin
        if (core_req || ldr_req) begin
          // Loader wins when alone, or on a tie when the core had the last grant.
          pick_ldr = ldr_req && (!core_req || (last_q == GRANT_CORE));
          we_d     = pick_ldr ? ldr_we    : core_we;
          addr_d   = pick_ldr ? ldr_addr  : core_addr;
          wdata_d  = pick_ldr ? ldr_wdata : core_wdata;
          grant_d  = pick_ldr;
          last_d   = pick_ldr;
          mem_wr_d = we_d;
          mem_rd_d = !we_d;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          core_ack_d = (grant_id == GRANT_CORE);
          ldr_ack_d  = (grant_id == GRANT_LDR);
          state_d    = S_DONE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter at zero marks the cycle in which mem_rd_data is valid.
        if (lat_q == '0) begin
          if (grant_id == GRANT_LDR) begin
            ldr_rdata_d = mem_rd_data;
          end else begin
            core_rdata_d = mem_rd_data;
          end
          core_ack_d = (grant_id == GRANT_CORE);
          ldr_ack_d  = (grant_id == GRANT_LDR);
          state_d    = S_DONE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);

    // Contention: both requesting and neither being acknowledged this cycle.
    if (core_req && ldr_req && !core_ack && !ldr_ack && (conflict_cnt != CNT_MAX)) begin
      cnt_d = conflict_cnt + CNT_W'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      lat_q        <= '0;
      we_q         <= 1'b0;
      last_q       <= GRANT_LDR;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      grant_id     <= GRANT_CORE;
      core_rdata   <= '0;
      ldr_rdata    <= '0;
      core_ack     <= 1'b0;
      ldr_ack      <= 1'b0;
      mem_wr       <= 1'b0;
      mem_rd       <= 1'b0;
      busy         <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      we_q         <= we_d;
      last_q       <= last_d;
      mem_addr     <= addr_d;
      mem_wr_data  <= wdata_d;
      grant_id     <= grant_d;
      core_rdata   <= core_rdata_d;
      ldr_rdata    <= ldr_rdata_d;
      core_ack     <= core_ack_d;
      ldr_ack      <= ldr_ack_d;
      mem_wr       <= mem_wr_d;
      mem_rd       <= mem_rd_d;
      busy         <= busy_d;
      conflict_cnt <= cnt_d;
    end
  end

  // Structural invariants of the sequencer.
  a_one_strobe: assert property (@(posedge clk) disable iff (!reset) !(mem_wr && mem_rd));
  a_one_ack:    assert property (@(posedge clk) disable iff (!reset) !(core_ack && ldr_ack));
  a_ack_pulse:  assert property (@(posedge clk) disable iff (!reset)
                                 (core_ack || ldr_ack) |=> !(core_ack || ldr_ack));

endmodule
